// File: rtl/esi_axis_tx_arbiter_pkg.sv
// Shared types and helpers for the ESI AXI-Stream TX arbiter.
// TDEST support is enabled by defining ESI_AXIS_ARB_TDEST_EN.
package esi_axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int MAX_REQ = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

    // First valid requester strictly after last_idx, wrapping at n.
    function automatic logic [3:0] rr_next(
        input logic [MAX_REQ-1:0] valid,
        input logic [3:0]         last_idx,
        input int                 n
    );
        logic [3:0] sel;
        logic       found;
        int         idx;
        sel   = last_idx;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(last_idx) + i) % n;
            if (!found && i <= n && valid[idx[3:0]]) begin
                sel   = idx[3:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/esi_axis_tx_arbiter_if.sv
// AXI-Stream sender channel bundle; TDEST only with ESI_AXIS_ARB_TDEST_EN.
interface esi_axis_tx_arbiter_if #(
    parameter int TDATA_WIDTH = 64
`ifdef ESI_AXIS_ARB_TDEST_EN
    , parameter int ID_W = 2
`endif
);
    logic                   TVALID;
    logic                   TREADY;
    logic                   TLAST;
    logic [TDATA_WIDTH-1:0] TDATA;
`ifdef ESI_AXIS_ARB_TDEST_EN
    logic [ID_W-1:0]        TDEST;

    modport master (output TVALID, TDATA, TLAST, TDEST, input TREADY);
    modport slave  (input TVALID, TDATA, TLAST, TDEST, output TREADY);
`else
    modport master (output TVALID, TDATA, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TLAST, output TREADY);
`endif
endinterface

// File: rtl/esi_axis_tx_arbiter_skid_buffer.sv
// Two-entry register slice: outputs come straight from flops,
// full throughput while out_ready stays high.
module esi_axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid;
                if (in_valid) out_data_d = in_data;
            end
        end else if (in_valid && !skid_valid_q) begin
            // Output stalled: park the beat so the producer side can run.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/esi_axis_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sender.
// Define ESI_AXIS_ARB_TDEST_EN to carry the source index on TDEST.
module esi_axis_tx_arbiter
    import esi_axis_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int TDATA_WIDTH   = 64,
    parameter int MAX_PKT_BEATS = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ*TDATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    esi_axis_tx_arbiter_if.master        m_axis,
    output logic [$clog2(N_REQ)-1:0]     grant_idx,
    output logic                         pkt_overflow
);
    localparam int IW = idx_w(N_REQ);
    localparam int CW = cnt_w(MAX_PKT_BEATS);
`ifdef ESI_AXIS_ARB_TDEST_EN
    localparam int PW = IW + 1 + TDATA_WIDTH;
`else
    localparam int PW = 1 + TDATA_WIDTH;
`endif

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    base_q, base_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [MAX_REQ-1:0]     vpad;
    logic [TDATA_WIDTH-1:0] g_data;
    logic                   g_last;
    logic                   force_last;
    logic                   acc;
    logic                   sk_in_ready;
    logic                   sk_out_valid;
    logic [PW-1:0]          sk_in_data;
    logic [PW-1:0]          sk_out_data;

    always_comb begin
        vpad             = '0;
        vpad[N_REQ-1:0]  = req_valid;
        g_data     = req_data[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
        g_last     = req_last[grant_q];
        force_last = (cnt_q == CW'(MAX_PKT_BEATS - 1)) && !g_last;
        acc        = (state_q == BUSY) && req_valid[grant_q] && sk_in_ready;

        req_ready = '0;
        if (state_q == BUSY) req_ready[grant_q] = sk_in_ready;

        state_d = state_q;
        grant_d = grant_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = IW'(rr_next(vpad, 4'(base_q), N_REQ));
                    base_d  = grant_d;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (g_last) begin
                        state_d = IDLE;
                    end else if (force_last) begin
                        // Rest of the packet re-arbitrates as a new one.
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            base_q  <= IW'(N_REQ - 1);
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef ESI_AXIS_ARB_TDEST_EN
    assign sk_in_data = {grant_q, g_last | force_last, g_data};
    assign m_axis.TDEST = sk_out_data[PW-1 -: IW];
`else
    assign sk_in_data = {g_last | force_last, g_data};
`endif

    esi_axis_skid_buffer #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (acc),
        .in_ready (sk_in_ready),
        .in_data  (sk_in_data),
        .out_valid(sk_out_valid),
        .out_ready(m_axis.TREADY),
        .out_data (sk_out_data)
    );

    assign m_axis.TVALID = sk_out_valid;
    assign m_axis.TDATA  = sk_out_data[TDATA_WIDTH-1:0];
    assign m_axis.TLAST  = sk_out_data[TDATA_WIDTH];
    assign grant_idx     = grant_q;
    assign pkt_overflow  = ovf_q;

endmodule

// File: tb/tb_esi_axis_tx_arbiter.sv
// Directed and randomized checks of esi_axis_tx_arbiter against a
// per-requester packet scoreboard.
module tb_esi_axis_tx_arbiter;
    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          tlast;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic          last;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] req_data  = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last  = '0;
    logic [N-1:0]    req_ready;
    logic [1:0]      grant_idx;
    logic            pkt_overflow;

    esi_axis_tx_arbiter_if #(
        .TDATA_WIDTH(DW)
`ifdef ESI_AXIS_ARB_TDEST_EN
        , .ID_W(2)
`endif
    ) axis ();

    esi_axis_tx_arbiter #(
        .N_REQ        (N),
        .TDATA_WIDTH  (DW),
        .MAX_PKT_BEATS(MAXB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_data    (req_data),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .m_axis      (axis),
        .grant_idx   (grant_idx),
        .pkt_overflow(pkt_overflow)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    beat_t         pq[N][$];
    beat_t         eq[N][$];
    obs_t          olog[$];
    int            seq[N];
    int            vprob = 100;
    logic          tr_mode = 1'b0;
    logic          tr_val  = 1'b1;
    logic          in_pkt  = 1'b0;
    int            cur_src = 0;
    logic          stall_pend = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic          ovf_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Expected TLAST: real end of packet or every MAXB-th beat.
    task automatic push_pkt(input int src, input int len);
        beat_t b;
        for (int j = 0; j < len; j++) begin
            b.data  = {4'(src), 28'(seq[src])};
            seq[src]++;
            b.last  = (j == len - 1);
            b.tlast = b.last || (j % MAXB == MAXB - 1);
            pq[src].push_back(b);
        end
        if (len > MAXB) ovf_exp = 1'b1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (pq[i].size() > 0) &&
                           ($urandom_range(99) < vprob);
            if (pq[i].size() > 0) begin
                req_data[i*DW +: DW] = pq[i][0].data;
                req_last[i]          = pq[i][0].last;
            end else begin
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
        axis.TREADY = tr_mode ? ($urandom_range(99) < 70) : tr_val;
    endtask

    task automatic sample();
        obs_t o;
        beat_t e;
        int src;
        logic ok;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] && pq[i].size() > 0)
                eq[i].push_back(pq[i].pop_front());
        end
        if (!rst)
            chk("ready_onehot", req_ready & ~(4'b0001 << grant_idx), '0);
        if (stall_pend && !rst) begin
            chk("hold_valid", axis.TVALID, 1);
            chk("hold_data", axis.TDATA, stall_data);
            chk("hold_last", axis.TLAST, stall_last);
        end
        if (axis.TVALID && axis.TREADY) begin
            src    = int'(axis.TDATA[DW-1 -: 4]);
            o.cyc  = cyc;
            o.data = axis.TDATA;
            o.last = axis.TLAST;
            olog.push_back(o);
            if (in_pkt) chk("pkt_contig", src, cur_src);
            ok = (src < N) ? (eq[src].size() > 0) : 1'b0;
            chk("beat_known", ok, 1);
            if (ok) begin
                e = eq[src].pop_front();
                chk("beat_data", axis.TDATA, e.data);
                chk("beat_last", axis.TLAST, e.tlast);
`ifdef ESI_AXIS_ARB_TDEST_EN
                chk("beat_tdest", axis.TDEST, 2'(src));
`endif
            end
            in_pkt  = !axis.TLAST;
            cur_src = src;
        end
        stall_pend = !rst && axis.TVALID && !axis.TREADY;
        stall_data = axis.TDATA;
        stall_last = axis.TLAST;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) eq[i].delete();
        in_pkt     = 1'b0;
        stall_pend = 1'b0;
        ovf_exp    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        tick();
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, acc, done;
        logic [5:0] exp_l;
        logic [DW-1:0] exp_d;
        int exp_s[8];

        for (int i = 0; i < N; i++) seq[i] = 0;
        axis.TREADY = 1'b1;

        // Reset state
        run(3);
        chk("rst_tvalid", axis.TVALID, 0);
        chk("rst_tlast", axis.TLAST, 0);
        chk("rst_tdata", axis.TDATA, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_ovf", pkt_overflow, 0);
        rst = 1'b0;
        tick();

        // Single requester 1, beats A,B,C
        seq[1] = 'hA;
        olog.delete();
        push_pkt(1, 3);
        tick();
        c0 = cyc;
        run(8);
        chk("t1_count", olog.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < olog.size()) begin
                exp_d = {4'd1, 28'hA + 28'(k)};
                chk("t1_cycle", olog[k].cyc, c0 + 2 + k);
                chk("t1_data", olog[k].data, exp_d);
                chk("t1_last", olog[k].last, (k == 2));
            end
        end
        chk("t1_grant", grant_idx, 1);

        // Requesters 0 and 2, two rounds of 2-beat packets
        do_reset();
        olog.delete();
        push_pkt(0, 2); push_pkt(2, 2);
        push_pkt(0, 2); push_pkt(2, 2);
        tick();
        c0 = cyc;
        run(18);
        chk("t2_count", olog.size(), 8);
        exp_s = '{0, 0, 2, 2, 0, 0, 2, 2};
        for (int k = 0; k < 8; k++)
            if (k < olog.size())
                chk("t2_src", olog[k].data[DW-1 -: 4], exp_s[k]);
        if (olog.size() >= 3) begin
            chk("t2_first", olog[0].cyc, c0 + 2);
            chk("t2_gap", olog[2].cyc - olog[1].cyc, 2);
        end

        // All four requesters, single-beat packets
        do_reset();
        olog.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push_pkt(i, 1);
        tick();
        run(30);
        chk("t3_count", olog.size(), 8);
        exp_s = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int k = 0; k < 8; k++)
            if (k < olog.size())
                chk("t3_src", olog[k].data[DW-1 -: 4], exp_s[k]);

        // TREADY low for 5 cycles mid-packet
        olog.delete();
        push_pkt(3, 4);
        tick();
        run(2);
        tr_val = 1'b0;
        axis.TREADY = 1'b0;
        run(5);
        chk("t4_tvalid", axis.TVALID, 1);
        acc = 4 - pq[3].size();
        chk("t4_absorb", (acc - olog.size()) <= 2, 1);
        tr_val = 1'b1;
        run(10);
        chk("t4_count", olog.size(), 4);
        if (olog.size() == 4) chk("t4_last", olog[3].last, 1);

        // Forced termination at MAXB beats
        do_reset();
        olog.delete();
        push_pkt(0, 6);
        tick();
        run(20);
        chk("t5_count", olog.size(), 6);
        exp_l = 6'b101000;
        for (int k = 0; k < 6; k++)
            if (k < olog.size()) chk("t5_last", olog[k].last, exp_l[k]);
        if (olog.size() >= 5)
            chk("t5_regrant_gap", olog[4].cyc - olog[3].cyc, 2);
        chk("t5_ovf", pkt_overflow, 1);

        // Reset mid-packet
        olog.delete();
        push_pkt(1, 5);
        tick();
        c0 = cyc;
        run(2);
        chk("t6_tvalid_pre", axis.TVALID, 1);
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        tick();
        chk("t6_tvalid_rst", axis.TVALID, 0);
        chk("t6_ready_rst", req_ready, 0);
        tick();
        rst = 1'b0;
        clear_model();
        olog.delete();
        chk("t6_ovf_clear", pkt_overflow, 0);
        chk("t6_grant", grant_idx, 0);
        push_pkt(3, 1); push_pkt(0, 1); push_pkt(2, 1);
        tick();
        run(14);
        chk("t6_count", olog.size(), 3);
        exp_s = '{0, 2, 3, 0, 0, 0, 0, 0};
        for (int k = 0; k < 3; k++)
            if (k < olog.size())
                chk("t6_src", olog[k].data[DW-1 -: 4], exp_s[k]);

        // Randomized traffic against the scoreboard
        do_reset();
        vprob   = 80;
        tr_mode = 1'b1;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++)
                if (pq[i].size() == 0 && $urandom_range(9) < 3)
                    push_pkt(i, int'($urandom_range(7, 1)));
            tick();
        end
        vprob   = 100;
        tr_mode = 1'b0;
        tr_val  = 1'b1;
        done    = 0;
        for (int t = 0; t < 600 && done == 0; t++) begin
            tick();
            done = 1;
            for (int i = 0; i < N; i++)
                if (pq[i].size() != 0 || eq[i].size() != 0) done = 0;
            if (axis.TVALID) done = 0;
        end
        chk("rand_drained", done, 1);
        chk("rand_ovf", pkt_overflow, ovf_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
